// File: rtl/uart_baud_gen_pkg.sv
// Shared constants and the {int, frac} divisor record for the UART baud generator.
package uart_baud_pkg;

  localparam int FRAC_W    = 4;
  localparam int DEF_DIV_C = 338;
  localparam int DIV_W_C   = 16;

  typedef struct packed {
    logic [DIV_W_C-1:0] div_int;
    logic [FRAC_W-1:0]  div_frac;
  } baud_div_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Configuration/enable inputs and strobe outputs of the baud generator.
interface uart_baud_gen_if
  import uart_baud_pkg::*;
#(
  parameter int DIV_W = 16
);

  logic [DIV_W-1:0]  baud_div;
  logic [FRAC_W-1:0] baud_frac;
  logic              cfg_ld;
  logic              tx_bps_en;
  logic              rx_bps_en;
  logic              rx_resync;
  logic              tx_bpsclk;
  logic              rx_bpsclk;
  logic              rx_os_tick;

  modport master (
    output baud_div, baud_frac, cfg_ld, tx_bps_en, rx_bps_en, rx_resync,
    input  tx_bpsclk, rx_bpsclk, rx_os_tick
  );

  modport slave (
    input  baud_div, baud_frac, cfg_ld, tx_bps_en, rx_bps_en, rx_resync,
    output tx_bpsclk, rx_bpsclk, rx_os_tick
  );

endinterface

// File: rtl/uart_baud_gen_chan.sv
// One baud channel (prescaler, oversample counter, optional UART_BAUD_FRAC_EN accumulator);
// strobes decode registered state with zero latency; no backpressure.
module uart_baud_chan
  import uart_baud_pkg::*;
#(
  parameter int        DIV_W   = 16,
  parameter int        OSR     = 16,
  parameter bit        MID_SEL = 1'b0,
  parameter baud_div_t DEF_VAL = '0
) (
  input  logic      clk26m,
  input  logic      rst26m_,
  input  logic      en_i,
  input  logic      resync_i,
  input  baud_div_t shadow_i,
  output logic      tick_o,
  output logic      bps_o
);

  localparam int              OS_W    = $clog2(OSR);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0] OS_STRB = MID_SEL ? OS_W'(OSR / 2 - 1) : OS_LAST;

  logic [DIV_W:0]  presc_q, presc_d, period;
  logic [OS_W-1:0] os_q, os_d;
  baud_div_t       act_q, act_d;
  logic            tick;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  assign period = (DIV_W+1)'(act_q.div_int) + (DIV_W+1)'(carry_q);
`else
  logic unused_frac;
  assign unused_frac = ^act_q.div_frac;
  assign period      = (DIV_W+1)'(act_q.div_int);
`endif

  // Reset gates the decode so a mid-bit reset kills any strobe immediately.
  assign tick   = rst26m_ && en_i && !resync_i && (presc_q == period);
  assign tick_o = tick;
  assign bps_o  = tick && (os_q == OS_STRB);

  always_comb begin
    presc_d = presc_q + {{DIV_W{1'b0}}, 1'b1};
    os_d    = os_q;
    act_d   = act_q;
`ifdef UART_BAUD_FRAC_EN
    acc_d   = acc_q;
    carry_d = carry_q;
`endif
    if (!en_i || resync_i) begin
      presc_d = '0;
      os_d    = '0;
      if (!en_i) act_d = shadow_i;
`ifdef UART_BAUD_FRAC_EN
      acc_d   = '0;
      carry_d = 1'b0;
`endif
    end else if (tick) begin
      presc_d = '0;
      os_d    = os_q + OS_W'(1);
`ifdef UART_BAUD_FRAC_EN
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, act_q.div_frac};
`endif
      // Divisor swaps only at the bit boundary so a bit never changes length midway.
      if (os_q == OS_LAST) act_d = shadow_i;
    end
  end

  always_ff @(posedge clk26m or negedge rst26m_) begin
    if (!rst26m_) begin
      presc_q <= '0;
      os_q    <= '0;
      act_q   <= DEF_VAL;
`ifdef UART_BAUD_FRAC_EN
      acc_q   <= '0;
      carry_q <= 1'b0;
`endif
    end else begin
      presc_q <= presc_d;
      os_q    <= os_d;
      act_q   <= act_d;
`ifdef UART_BAUD_FRAC_EN
      acc_q   <= acc_d;
      carry_q <= carry_d;
`endif
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: shadow divisor plus independent tx/rx channels; fractional
// divisor only with UART_BAUD_FRAC_EN. Strobes are zero-latency one-cycle pulses, no backpressure.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int OSR     = 16,
  parameter int DEF_DIV = DEF_DIV_C
) (
  input  logic            clk26m,
  input  logic            rst26m_,
  uart_baud_gen_if.slave  bus
);

  localparam baud_div_t DEF_SHADOW = baud_div_t'({DIV_W_C'(DEF_DIV), FRAC_W'(0)});

  baud_div_t shadow_q, shadow_d;
  logic      unused_tx_tick;

  always_comb begin
    shadow_d = shadow_q;
    if (bus.cfg_ld) begin
      shadow_d.div_int  = DIV_W_C'(bus.baud_div);
`ifdef UART_BAUD_FRAC_EN
      shadow_d.div_frac = bus.baud_frac;
`else
      shadow_d.div_frac = '0;
`endif
    end
  end

`ifndef UART_BAUD_FRAC_EN
  logic unused_frac;
  assign unused_frac = ^bus.baud_frac;
`endif

  always_ff @(posedge clk26m or negedge rst26m_) begin
    if (!rst26m_) shadow_q <= DEF_SHADOW;
    else          shadow_q <= shadow_d;
  end

  uart_baud_chan #(
    .DIV_W(DIV_W), .OSR(OSR), .MID_SEL(1'b0), .DEF_VAL(DEF_SHADOW)
  ) u_tx (
    .clk26m   (clk26m),
    .rst26m_  (rst26m_),
    .en_i     (bus.tx_bps_en),
    .resync_i (1'b0),
    .shadow_i (shadow_q),
    .tick_o   (unused_tx_tick),
    .bps_o    (bus.tx_bpsclk)
  );

  uart_baud_chan #(
    .DIV_W(DIV_W), .OSR(OSR), .MID_SEL(1'b1), .DEF_VAL(DEF_SHADOW)
  ) u_rx (
    .clk26m   (clk26m),
    .rst26m_  (rst26m_),
    .en_i     (bus.rx_bps_en),
    .resync_i (bus.rx_resync),
    .shadow_i (shadow_q),
    .tick_o   (bus.rx_os_tick),
    .bps_o    (bus.rx_bpsclk)
  );

endmodule
